// File: rtl/lsu_ctrl_pkg.sv
// Shared load/store definitions: funct3 size codes, LSU FSM states and
// the size/alignment legality helpers used by decode and the LSU.
package lsu_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] ofs);
    case (op)
      F3_H, F3_HU: return ofs[0];
      F3_W:        return ofs != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store mask/data replication and load extract/extend.
module lsu_align import lsu_ctrl_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op_i,
  input  logic [1:0]       ofs_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [WIDTH-1:0] rdata_i,
  output logic [3:0]       wmask_o,
  output logic [WIDTH-1:0] wdata_o,
  output logic [WIDTH-1:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{ofs_i, 3'b000} +: 8];
    half_sel = ofs_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    wmask_o  = 4'b0000;
    wdata_o  = '0;
    rdata_o  = '0;
    case (op_i)
      F3_B, F3_BU: begin
        wmask_o = 4'b0001 << ofs_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = op_i[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      F3_H, F3_HU: begin
        wmask_o = 4'b0011 << ofs_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = op_i[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      F3_W: begin
        wmask_o = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store unit: latches one EXU access, issues one
// word-aligned memory request and returns the extended result.
module lsu_ctrl import lsu_ctrl_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_we,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_addr,
  input  logic [WIDTH-1:0] in_wdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_rdata,
  output logic             out_err,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic             mem_req_we,
  output logic [WIDTH-1:0] mem_req_addr,
  output logic [WIDTH-1:0] mem_req_wdata,
  output logic [3:0]       mem_req_wmask,
  input  logic             mem_resp_valid,
  input  logic [WIDTH-1:0] mem_resp_data,
  input  logic             mem_resp_err
);

  lsu_state_e       state_q;
  logic             we_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic             in_ready_q;
  logic             mem_req_valid_q;
  logic             out_valid_q;
  logic             out_err_q;
  logic [WIDTH-1:0] out_rdata_q;

  logic [3:0]       al_wmask;
  logic [WIDTH-1:0] al_wdata;
  logic [WIDTH-1:0] al_rdata;

  lsu_align #(.WIDTH(WIDTH)) u_align (
    .op_i    (op_q),
    .ofs_i   (addr_q[1:0]),
    .wdata_i (wdata_q),
    .rdata_i (mem_resp_data),
    .wmask_o (al_wmask),
    .wdata_o (al_wdata),
    .rdata_o (al_rdata)
  );

  // Request fields come straight from the latched access, so they hold
  // steady for the whole REQ phase without extra registers.
  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_rdata     = out_rdata_q;
  assign out_err       = out_err_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_we    = we_q;
  assign mem_req_addr  = {addr_q[WIDTH-1:2], 2'b00};
  assign mem_req_wmask = we_q ? al_wmask : 4'b0000;
  assign mem_req_wdata = we_q ? al_wdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      we_q            <= 1'b0;
      op_q            <= 3'b000;
      addr_q          <= '0;
      wdata_q         <= '0;
      in_ready_q      <= 1'b1;
      mem_req_valid_q <= 1'b0;
      out_valid_q     <= 1'b0;
      out_err_q       <= 1'b0;
      out_rdata_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          we_q       <= in_we;
          op_q       <= in_op;
          addr_q     <= in_addr;
          wdata_q    <= in_wdata;
          in_ready_q <= 1'b0;
          // Illegal size or bad alignment short-circuits to DONE, no bus traffic.
          if (!op_legal(in_op) || misaligned(in_op, in_addr[1:0])) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            out_err_q   <= 1'b1;
            out_rdata_q <= '0;
          end else begin
            state_q         <= S_REQ;
            mem_req_valid_q <= 1'b1;
          end
        end
        S_REQ: if (mem_req_ready) begin
          mem_req_valid_q <= 1'b0;
          state_q         <= S_WAIT;
        end
        S_WAIT: if (mem_resp_valid) begin
          state_q     <= S_DONE;
          out_valid_q <= 1'b1;
          out_err_q   <= mem_resp_err;
          out_rdata_q <= (mem_resp_err || we_q) ? '0 : al_rdata;
        end
        S_DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed spec cases, then randomized traffic
// against a byte-level reference model, with a stalling memory and random sink.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_ready, in_we;
  logic [2:0]  in_op;
  logic [31:0] in_addr, in_wdata;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid, mem_resp_err;
  logic [31:0] mem_resp_data;

  lsu_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we), .in_op(in_op),
    .in_addr(in_addr), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err)
  );

  always #5 clk = ~clk;

  typedef struct { bit we; bit [31:0] addr; bit [31:0] wdata; bit [3:0] wmask; } req_t;
  typedef struct { bit [31:0] data; bit err; } rsp_t;
  typedef struct { bit [31:0] rdata; bit err; int lat; } out_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  out_t out_q[$];

  int checks = 0, passes = 0;
  int cyc = 0, acc_cyc = 0;
  bit inflight = 0, fast = 0, noresp = 0, first_seen = 0;
  int stall_force = -1, dly_force = -1, out_hold = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input bit [31:0] act, input bit [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference model: sizes in bytes, lanes by address modulo 4.
  function automatic void model(input bit we, input bit [2:0] op, input bit [31:0] addr,
                                input bit [31:0] wdata, input bit [31:0] rdata, input bit rerr,
                                output bit iss, output bit [31:0] ewd, output bit [3:0] ewm,
                                output bit [31:0] erd, output bit eerr);
    int sz, ofs;
    bit [31:0] v, m;
    sz  = 1 << op[1:0];
    ofs = int'(addr % 4);
    ewd = 0; ewm = 0; erd = 0;
    if (!(op == 0 || op == 1 || op == 2 || op == 4 || op == 5) || (ofs % sz) != 0) begin
      iss = 0; eerr = 1;
      return;
    end
    iss = 1;
    if (we) begin
      ewm = 4'(((1 << sz) - 1) << ofs);
      for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wdata[8*(i % sz) +: 8];
    end
    m = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*sz)) - 32'd1);
    v = (rdata >> (8*ofs)) & m;
    if (!op[2] && sz < 4 && v[8*sz-1]) v = v | ~m;
    erd  = (rerr || we) ? 32'd0 : v;
    eerr = rerr;
  endfunction

  task automatic issue_x(input bit we, input bit [2:0] op, input bit [31:0] addr,
                         input bit [31:0] wdata, input bit [31:0] rdata, input bit rerr,
                         input bit iss, input bit [31:0] ewd, input bit [3:0] ewm,
                         input bit [31:0] erd, input bit eerr, input int lat);
    req_t r; rsp_t p; out_t o; int n;
    if (iss) begin
      r.we = we; r.addr = {addr[31:2], 2'b00}; r.wdata = ewd; r.wmask = ewm;
      req_q.push_back(r);
      p.data = rdata; p.err = rerr;
      rsp_q.push_back(p);
    end
    o.rdata = erd; o.err = eerr; o.lat = lat;
    out_q.push_back(o);
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 1000) begin
        checks++;
        $display("FAIL in_ready: timeout waiting to issue");
        $fatal(1, "issue timeout");
      end
      // Junk requests while busy must be ignored.
      in_valid = !fast && ($urandom_range(0, 3) == 0);
      in_we = 1'($urandom); in_op = 3'($urandom); in_addr = $urandom; in_wdata = $urandom;
    end
    in_valid = 1; in_we = we; in_op = op; in_addr = addr; in_wdata = wdata;
    @(posedge clk); #1;
    acc_cyc = cyc; inflight = 1; in_valid = 0;
  endtask

  task automatic issue(input bit we, input bit [2:0] op, input bit [31:0] addr,
                       input bit [31:0] wdata, input bit [31:0] rdata, input bit rerr);
    bit iss, eerr; bit [31:0] ewd, erd; bit [3:0] ewm;
    model(we, op, addr, wdata, rdata, rerr, iss, ewd, ewm, erd, eerr);
    issue_x(we, op, addr, wdata, rdata, rerr, iss, ewd, ewm, erd, eerr, -1);
  endtask

  task automatic drain();
    int n = 0;
    while (out_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 2000) begin
        checks++;
        $display("FAIL drain: timeout with %0d responses pending", out_q.size());
        $fatal(1, "drain timeout");
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "in_ready"}, 32'(in_ready), 1);
    chk({tag, "out_valid"}, 32'(out_valid), 0);
    chk({tag, "out_rdata"}, out_rdata, 0);
    chk({tag, "out_err"}, 32'(out_err), 0);
    chk({tag, "mem_req_valid"}, 32'(mem_req_valid), 0);
    chk({tag, "mem_req_we"}, 32'(mem_req_we), 0);
    chk({tag, "mem_req_addr"}, mem_req_addr, 0);
    chk({tag, "mem_req_wdata"}, mem_req_wdata, 0);
    chk({tag, "mem_req_wmask"}, 32'(mem_req_wmask), 0);
  endtask

  // Output monitor / sink
  initial begin
    out_ready = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("in_ready", 32'(in_ready), 32'(!inflight));
        if (out_valid) begin
          if (out_q.size() == 0) begin
            checks++;
            $display("FAIL out_valid: unexpected response rdata=0x%08h err=%0d", out_rdata, out_err);
          end else begin
            chk("out_rdata", out_rdata, out_q[0].rdata);
            chk("out_err", 32'(out_err), 32'(out_q[0].err));
            if (!first_seen) begin
              first_seen = 1;
              if (out_q[0].lat > 0) chk("latency", 32'(cyc - acc_cyc + 1), 32'(out_q[0].lat));
            end
            if (out_hold > 0) begin
              out_ready = 0;
              out_hold--;
            end else out_ready = fast ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (out_ready) begin
              void'(out_q.pop_front());
              first_seen = 0;
              inflight = 0;
            end
          end
        end else out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Memory model: stalls, checks request stability, returns queued response
  initial begin
    req_t r; rsp_t p; int st, dl;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0; mem_resp_err = 0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 0;
      if (!rst && mem_req_valid) begin
        if (req_q.size() == 0) begin
          checks++;
          $display("FAIL mem_req_valid: unexpected request addr=0x%08h", mem_req_addr);
          mem_req_ready = 1; @(negedge clk); mem_req_ready = 0;
        end else begin
          r  = req_q.pop_front();
          p  = rsp_q.pop_front();
          st = (stall_force >= 0) ? stall_force : (fast ? 0 : $urandom_range(0, 3));
          dl = (dly_force >= 0) ? dly_force : (fast ? 0 : $urandom_range(0, 3));
          for (int i = 0; i <= st; i++) begin
            if (i > 0) @(negedge clk);
            chk("mem_req_valid", 32'(mem_req_valid), 1);
            chk("mem_req_we", 32'(mem_req_we), 32'(r.we));
            chk("mem_req_addr", mem_req_addr, r.addr);
            chk("mem_req_wdata", mem_req_wdata, r.wdata);
            chk("mem_req_wmask", 32'(mem_req_wmask), 32'(r.wmask));
          end
          mem_req_ready = 1;
          @(negedge clk);
          mem_req_ready = 0;
          chk("mem_req_valid_drop", 32'(mem_req_valid), 0);
          if (noresp) repeat (6) @(negedge clk);
          else repeat (dl) @(negedge clk);
          mem_resp_valid = 1; mem_resp_data = p.data; mem_resp_err = p.err;
          @(negedge clk);
          mem_resp_valid = 0; mem_resp_data = $urandom;
        end
      end else if (!fast && $urandom_range(0, 5) == 0) begin
        // Stray response with nothing outstanding must be ignored.
        mem_resp_valid = 1; mem_resp_data = $urandom; mem_resp_err = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [2:0] ops [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7, 3'd2, 3'd0};
    in_valid = 0; in_we = 0; in_op = 0; in_addr = 0; in_wdata = 0;
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    chk_rst("reset ");

    fast = 1;
    issue_x(0, 3'b010, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 0, 1, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 3);
    issue_x(0, 3'b000, 32'h8000_0003, 32'h0, 32'h8011_2233, 0, 1, 32'h0, 4'h0, 32'hFFFF_FF80, 0, 3);
    issue_x(0, 3'b100, 32'h8000_0003, 32'h0, 32'h8011_2233, 0, 1, 32'h0, 4'h0, 32'h0000_0080, 0, 3);
    issue_x(0, 3'b101, 32'h8000_0002, 32'h0, 32'h8011_2233, 0, 1, 32'h0, 4'h0, 32'h0000_8011, 0, 3);
    issue_x(1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 32'h5555_5555, 0, 1, 32'hABCD_ABCD, 4'b1100, 32'h0, 0, 3);
    issue_x(0, 3'b010, 32'h8000_0006, 32'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 1, 1);
    issue_x(0, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 1, 1);
    issue_x(0, 3'b010, 32'h8000_0008, 32'h0, 32'h1234_5678, 1, 1, 32'h0, 4'h0, 32'h0, 1, 3);
    drain();

    // Stalled request, delayed response, back-pressured output
    stall_force = 4; dly_force = 2; out_hold = 3;
    issue_x(1, 3'b000, 32'h8000_0011, 32'h0000_00A5, 32'h0, 0, 1, 32'hA5A5_A5A5, 4'b0010, 32'h0, 0, -1);
    drain();
    stall_force = -1; dly_force = -1; out_hold = 0;

    // Reset while waiting for a response; the late response must be dropped
    noresp = 1;
    issue_x(0, 3'b010, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 0, 1, 32'h0, 4'h0, 32'hCAFE_F00D, 0, -1);
    repeat (2) @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    inflight = 0; first_seen = 0; out_q.delete();
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      chk_rst("post_rst ");
      @(negedge clk);
    end
    noresp = 0;

    fast = 0;
    for (int t = 0; t < 200; t++) begin
      issue(1'($urandom_range(0, 1)), ops[$urandom_range(0, 9)], $urandom, $urandom, $urandom,
            $urandom_range(0, 7) == 0);
    end
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
